// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback stage.
//   - funct3 load-size codes
//   - buffered entry struct. Its fields are sized for the widest build
//     (XLEN 64, register index up to 8 bits); narrower builds zero-extend
//     into it.
//   - helper that derives the byte-offset width from XLEN
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam int WB_XLEN_MAX  = 64;
  localparam int WB_REG_W_MAX = 8;

  typedef struct packed {
    logic                    valid;
    logic                    wr;
    logic [WB_REG_W_MAX-1:0] rd;
    logic [WB_XLEN_MAX-1:0]  data;
  } wb_entry_t;

  // Number of low address bits that select a byte within one XLEN word.
  function automatic int wb_ofs_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/wb_stage_buf_load_fmt.sv
// wb_load_fmt: combinational load-data formatter.
// Extracts a byte, half, word or dword from the aligned memory word and
// applies sign or zero extension according to funct3. When is_load is 0,
// alu_data passes straight through.
// Ports:
//   is_load   : select formatted load data instead of alu_data
//   funct3    : load size/sign code
//   addr_lo   : byte offset within the XLEN word
//   alu_data  : ALU/JAL result
//   mem_rdata : raw aligned memory word
//   data_o    : value to capture into the writeback buffer
module wb_load_fmt
  import wb_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int OFS_W = wb_ofs_w(XLEN)
) (
  input  logic             is_load,
  input  logic [2:0]       funct3,
  input  logic [OFS_W-1:0] addr_lo,
  input  logic [XLEN-1:0]  alu_data,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [XLEN-1:0]  data_o
);

  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     word_v;
  logic [XLEN-1:0] load_v;

  // Byte offset scaled to a bit offset. The half lane ignores addr_lo[0].
  assign byte_v = mem_rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = mem_rdata[{addr_lo[OFS_W-1:1], 4'b0000} +: 16];

  if (XLEN == 64) begin : g_word64
    assign word_v = addr_lo[OFS_W-1] ? mem_rdata[XLEN-1:32] : mem_rdata[31:0];
  end else begin : g_word32
    assign word_v = mem_rdata[31:0];
  end

  always_comb begin
    load_v = mem_rdata;
    case (funct3)
      F3_LB:  load_v = XLEN'($signed(byte_v));
      F3_LH:  load_v = XLEN'($signed(half_v));
      F3_LW:  load_v = XLEN'($signed(word_v));
      F3_LBU: load_v = XLEN'(byte_v);
      F3_LHU: load_v = XLEN'(half_v);
      // On a 32-bit build word_v is the whole word, so LWU collapses to
      // the pass-through case.
      F3_LWU: load_v = XLEN'(word_v);
      // LD is the full aligned dword, i.e. the raw word.
      default: load_v = mem_rdata;
    endcase
  end

  assign data_o = is_load ? load_v : alu_data;

endmodule

// File: rtl/wb_stage_buf.sv
// wb_stage_buf: registered, back-pressured writeback stage.
// Sits between MEM and the register-file write port. Incoming instructions
// are formatted (load extraction or ALU result), qualified (no writes to
// x0) and captured into a 2-entry buffer: head H feeds the register file,
// skid S absorbs one extra instruction while the register file stalls.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_*            : MEM-stage request (valid/ready handshake)
//   rf_*            : register-file write request (valid/ready handshake)
//   fwd0_*          : head (older) entry forwarding tap
//   fwd1_*          : skid (younger) entry tap; consumers give it priority
//   retire_cnt      : number of entries drained from the head, wrapping
module wb_stage_buf
  import wb_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int REG_W = 5,
  parameter  int CNT_W = 32,
  localparam int OFS_W = wb_ofs_w(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_we,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic [OFS_W-1:0] in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_data,
  input  logic [XLEN-1:0]  in_mem_rdata,
  output logic             rf_valid,
  input  logic             rf_ready,
  output logic [REG_W-1:0] rf_rd,
  output logic [XLEN-1:0]  rf_data,
  output logic             fwd0_valid,
  output logic [REG_W-1:0] fwd0_rd,
  output logic [XLEN-1:0]  fwd0_data,
  output logic             fwd1_valid,
  output logic [REG_W-1:0] fwd1_rd,
  output logic [XLEN-1:0]  fwd1_data,
  output logic [CNT_W-1:0] retire_cnt
);

  wb_entry_t        h_q, h_d;
  wb_entry_t        s_q, s_d;
  wb_entry_t        cap;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  fmt_data;
  logic             accept;
  logic             drain;

  wb_load_fmt #(.XLEN(XLEN)) u_fmt (
    .is_load   (in_is_load),
    .funct3    (in_funct3),
    .addr_lo   (in_addr_lo),
    .alu_data  (in_alu_data),
    .mem_rdata (in_mem_rdata),
    .data_o    (fmt_data)
  );

  // Incoming entry as it would be captured this cycle.
  always_comb begin
    cap       = '0;
    cap.valid = 1'b1;
    cap.wr    = in_we && (in_rd != '0);
    cap.rd    = WB_REG_W_MAX'(in_rd);
    cap.data  = WB_XLEN_MAX'(fmt_data);
  end

  // Ready depends only on the skid flop (and reset), never on rf_ready.
  assign in_ready = !s_q.valid && !rst;
  assign accept   = in_valid && in_ready;
  // An entry that does not write the register file leaves without waiting.
  assign drain    = h_q.valid && (!h_q.wr || rf_ready);

  always_comb begin
    h_d   = h_q;
    s_d   = s_q;
    cnt_d = cnt_q + CNT_W'(drain);
    if (drain) begin
      h_d = s_q.valid ? s_q : '0;
      s_d = '0;
    end
    // accept implies S is empty, so the new entry lands in H whenever H
    // is free after this edge, otherwise it parks in S.
    if (accept) begin
      if (!h_q.valid || drain) h_d = cap;
      else                     s_d = cap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      h_q   <= h_d;
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs read as idle for the whole reset cycle, not just afterwards.
  always_comb begin
    rf_valid   = !rst && h_q.valid && h_q.wr;
    rf_rd      = rst ? '0 : h_q.rd[REG_W-1:0];
    rf_data    = rst ? '0 : h_q.data[XLEN-1:0];
    fwd0_valid = rf_valid;
    fwd0_rd    = rf_rd;
    fwd0_data  = rf_data;
    fwd1_valid = !rst && s_q.valid && s_q.wr;
    fwd1_rd    = rst ? '0 : s_q.rd[REG_W-1:0];
    fwd1_data  = rst ? '0 : s_q.data[XLEN-1:0];
  end

  assign retire_cnt = cnt_q;

  // Upper bits of the shared entry struct are unused on narrow builds.
  logic unused_hi;
  assign unused_hi = ^{h_q, s_q};

endmodule
